// File: rtl/mmu_pkg.sv
// Shared MMU definitions: walker state encoding, PTE bit positions and
// the VPN/PPN/ASID field widths (also consumed by the TLB).
package mmu_pkg;

    localparam int VPN_W  = 20;
    localparam int PPN_W  = 20;
    localparam int ASID_W = 8;

    // PTE bit positions
    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_PPN_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L1_REQ  = 3'd1,
        ST_L1_WAIT = 3'd2,
        ST_L0_REQ  = 3'd3,
        ST_L0_WAIT = 3'd4,
        ST_REFILL  = 3'd5,
        ST_FAULT   = 3'd6
    } walk_state_e;

    // PPN field of a PTE
    function automatic logic [PPN_W-1:0] pte_ppn(input logic [31:0] pte);
        return pte[PTE_PPN_LSB +: PPN_W];
    endfunction

endpackage

// File: rtl/sv32_page_walker_pte_check.sv
// Combinational PTE classification for one walk level.
// level_i = 1 for the root (L1) table, 0 for the leaf (L0) table.
module pte_check
    import mmu_pkg::*;
(
    input  logic [31:0] pte_i,
    input  logic        level_i,
    output logic        is_leaf_o,
    output logic        is_fault_o,
    output logic        is_misaligned_o
);

    logic v, r, w, x;
    logic bad_enc;
    logic unused_pte;

    assign v = pte_i[PTE_V];
    assign r = pte_i[PTE_R];
    assign w = pte_i[PTE_W];
    assign x = pte_i[PTE_X];

    // Invalid, or the reserved write-only encoding
    assign bad_enc = ~v | (w & ~r);

    assign is_leaf_o = r | x;

    // A level-1 leaf maps a 4 MB superpage; its low PPN bits must be zero
    assign is_misaligned_o = level_i & is_leaf_o & (pte_i[PTE_PPN_LSB +: 10] != 10'd0);

    // A pointer found at level 0 has nowhere further to go
    assign is_fault_o = bad_enc | is_misaligned_o | (~level_i & ~is_leaf_o);

    // Permission/global bits and upper PPN are not needed for classification
    assign unused_pte = ^{pte_i[31:22], pte_i[11:4]};

endmodule

// File: rtl/sv32_page_walker.sv
// Two-level Sv32 hardware page-table walker. Accepts a TLB miss, issues
// one PTE read per level, and produces either a 4 KB TLB refill (superpages
// are split using the faulting VPN's low bits) or a page-fault pulse.
module sv32_page_walker
    import mmu_pkg::*;
#(
    parameter int VPN_WIDTH  = VPN_W,
    parameter int PPN_WIDTH  = PPN_W,
    parameter int ASID_WIDTH = ASID_W
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [VPN_WIDTH-1:0]  miss_vpn_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    input  logic [PPN_WIDTH-1:0]  satp_ppn_i,
    input  logic                  abort_i,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [31:0]           mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [31:0]           mem_resp_data_i,

    output logic                  refill_valid_o,
    output logic [VPN_WIDTH-1:0]  refill_vpn_o,
    output logic [PPN_WIDTH-1:0]  refill_ppn_o,
    output logic [ASID_WIDTH-1:0] refill_asid_o,
    output logic [3:0]            refill_flags_o,
    output logic                  refill_global_o,

    output logic                  fault_valid_o,
    output logic [VPN_WIDTH-1:0]  fault_vpn_o,

    output logic                  busy_o
);

    walk_state_e           state_q;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  kill_q;
    logic                  miss_ready_q;
    logic                  busy_q;
    logic                  mem_req_valid_q;
    logic [31:0]           mem_req_addr_q;
    logic                  refill_valid_q;
    logic [VPN_WIDTH-1:0]  refill_vpn_q;
    logic [PPN_WIDTH-1:0]  refill_ppn_q;
    logic [ASID_WIDTH-1:0] refill_asid_q;
    logic [3:0]            refill_flags_q;
    logic                  refill_global_q;
    logic                  fault_valid_q;
    logic [VPN_WIDTH-1:0]  fault_vpn_q;

    logic                  lvl_l1;
    logic                  pte_leaf, pte_fault, pte_misaligned;
    logic                  walk_fault;
    logic [PPN_WIDTH-1:0]  resp_ppn;

    // Response decode is always for the level currently being waited on
    assign lvl_l1   = (state_q == ST_L1_WAIT);
    assign resp_ppn = pte_ppn(mem_resp_data_i);

    pte_check u_pte_check (
        .pte_i           (mem_resp_data_i),
        .level_i         (lvl_l1),
        .is_leaf_o       (pte_leaf),
        .is_fault_o      (pte_fault),
        .is_misaligned_o (pte_misaligned)
    );

    assign walk_fault = pte_fault | pte_misaligned;

    // Walk FSM with registered handshake, request and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            vpn_q           <= '0;
            asid_q          <= '0;
            kill_q          <= 1'b0;
            miss_ready_q    <= 1'b1;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            refill_valid_q  <= 1'b0;
            refill_vpn_q    <= '0;
            refill_ppn_q    <= '0;
            refill_asid_q   <= '0;
            refill_flags_q  <= '0;
            refill_global_q <= 1'b0;
            fault_valid_q   <= 1'b0;
            fault_vpn_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (miss_valid_i) begin
                        vpn_q           <= miss_vpn_i;
                        asid_q          <= miss_asid_i;
                        mem_req_addr_q  <= {satp_ppn_i, miss_vpn_i[19:10], 2'b00};
                        mem_req_valid_q <= 1'b1;
                        miss_ready_q    <= 1'b0;
                        busy_q          <= 1'b1;
                        state_q         <= ST_L1_REQ;
                    end
                end

                ST_L1_REQ, ST_L0_REQ: begin
                    if (abort_i) kill_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q <= (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
                    end
                end

                ST_L1_WAIT, ST_L0_WAIT: begin
                    if (abort_i) kill_q <= 1'b1;
                    if (mem_resp_valid_i) begin
                        if (kill_q || abort_i) begin
                            // Killed walk: response swallowed, nothing reported
                            miss_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else if (walk_fault) begin
                            fault_vpn_q   <= vpn_q;
                            fault_valid_q <= 1'b1;
                            state_q       <= ST_FAULT;
                        end else if (pte_leaf) begin
                            refill_vpn_q    <= vpn_q;
                            refill_asid_q   <= asid_q;
                            refill_flags_q  <= mem_resp_data_i[PTE_U:PTE_R];
                            refill_global_q <= mem_resp_data_i[PTE_G];
                            // Superpage leaf is split into the 4 KB page that missed
                            refill_ppn_q    <= lvl_l1 ? {resp_ppn[19:10], vpn_q[9:0]} : resp_ppn;
                            refill_valid_q  <= 1'b1;
                            state_q         <= ST_REFILL;
                        end else begin
                            // L1 pointer: descend into the L0 table
                            mem_req_addr_q  <= {resp_ppn, vpn_q[9:0], 2'b00};
                            mem_req_valid_q <= 1'b1;
                            state_q         <= ST_L0_REQ;
                        end
                    end
                end

                ST_REFILL, ST_FAULT: begin
                    refill_valid_q <= 1'b0;
                    fault_valid_q  <= 1'b0;
                    miss_ready_q   <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= ST_IDLE;
                end

                default: begin
                    mem_req_valid_q <= 1'b0;
                    refill_valid_q  <= 1'b0;
                    fault_valid_q   <= 1'b0;
                    miss_ready_q    <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign miss_ready_o    = miss_ready_q;
    assign busy_o          = busy_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;

    // An sfence landing on the result cycle cancels the pulse outright
    assign refill_valid_o  = refill_valid_q & ~abort_i;
    assign fault_valid_o   = fault_valid_q  & ~abort_i;

    assign refill_vpn_o    = refill_vpn_q;
    assign refill_ppn_o    = refill_ppn_q;
    assign refill_asid_o   = refill_asid_q;
    assign refill_flags_o  = refill_flags_q;
    assign refill_global_o = refill_global_q;
    assign fault_vpn_o     = fault_vpn_q;

endmodule

// File: tb/tb_sv32_page_walker.sv
// Directed bench for sv32_page_walker: a bench-side memory answers PTE
// reads with programmable ready/response delays; each walk is checked for
// request addresses, result cycle, pulse width and refill/fault fields.
module tb_sv32_page_walker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miss_valid_i = 1'b0;
    logic        miss_ready_o;
    logic [19:0] miss_vpn_i = '0;
    logic [7:0]  miss_asid_i = '0;
    logic [19:0] satp_ppn_i = '0;
    logic        abort_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_data_i = '0;
    logic        refill_valid_o;
    logic [19:0] refill_vpn_o;
    logic [19:0] refill_ppn_o;
    logic [7:0]  refill_asid_o;
    logic [3:0]  refill_flags_o;
    logic        refill_global_o;
    logic        fault_valid_o;
    logic [19:0] fault_vpn_o;
    logic        busy_o;

    sv32_page_walker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_valid_i     (miss_valid_i),
        .miss_ready_o     (miss_ready_o),
        .miss_vpn_i       (miss_vpn_i),
        .miss_asid_i      (miss_asid_i),
        .satp_ppn_i       (satp_ppn_i),
        .abort_i          (abort_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .refill_valid_o   (refill_valid_o),
        .refill_vpn_o     (refill_vpn_o),
        .refill_ppn_o     (refill_ppn_o),
        .refill_asid_o    (refill_asid_o),
        .refill_flags_o   (refill_flags_o),
        .refill_global_o  (refill_global_o),
        .fault_valid_o    (fault_valid_o),
        .fault_vpn_o      (fault_vpn_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- bench memory ----------------
    logic [31:0] mem [logic [31:0]];
    int          rdy_dly = 0;
    int          rsp_dly = 0;
    logic [31:0] req_log [$];
    int          addr_unstable = 0;

    initial begin : responder
        int          rs;
        int          cnt;
        logic [31:0] a;
        rs = 0; cnt = 0; a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rs = 0; cnt = 0;
                mem_req_ready_i  = 1'b0;
                mem_resp_valid_i = 1'b0;
                mem_resp_data_i  = '0;
            end else begin
                if (rs == 3) begin
                    mem_resp_valid_i = 1'b0;
                    mem_resp_data_i  = '0;
                    rs = 0;
                end
                if (rs == 0) begin
                    mem_req_ready_i = 1'b0;
                    if (mem_req_valid_o) begin
                        if (cnt == 0) a = mem_req_addr_o;
                        else if (mem_req_addr_o !== a) addr_unstable++;
                        if (cnt < rdy_dly) cnt++;
                        else begin
                            mem_req_ready_i = 1'b1;
                            req_log.push_back(a);
                            cnt = 0;
                            rs = 2;
                        end
                    end
                end else if (rs == 2) begin
                    mem_req_ready_i = 1'b0;
                    if (cnt < rsp_dly) cnt++;
                    else begin
                        mem_resp_valid_i = 1'b1;
                        mem_resp_data_i  = mem.exists(a) ? mem[a] : 32'h0;
                        cnt = 0;
                        rs = 3;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] logged(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // ---------------- walk driver / observer ----------------
    int          n_refill, n_fault, refill_k, fault_k, done_k, first_req_k;
    int          busy_bad = 0;
    logic [19:0] cap_ppn, cap_vpn, cap_fvpn;
    logic [7:0]  cap_asid;
    logic [3:0]  cap_flags;
    logic        cap_glb;

    // Cycle k counts from the edge that accepted the miss (k=1 is the next cycle)
    task automatic run_walk(input logic [19:0] vpn, input logic [7:0] asid,
                            input logic [19:0] satp, input int abort_k, input int reset_k);
        n_refill = 0; n_fault = 0; refill_k = -1; fault_k = -1;
        done_k = -1; first_req_k = -1;
        cap_ppn = '0; cap_vpn = '0; cap_fvpn = '0; cap_asid = '0; cap_flags = '0; cap_glb = 1'b0;
        req_log.delete();
        @(negedge clk);
        miss_valid_i = 1'b1; miss_vpn_i = vpn; miss_asid_i = asid; satp_ppn_i = satp;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            miss_valid_i = 1'b0;
            abort_i = (k == abort_k);
            if (k == reset_k) begin
                abort_i = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_miss_ready", 32'(miss_ready_o), 32'd1);
                chk("rst_mid_busy",       32'(busy_o), 32'd0);
                chk("rst_mid_req_valid",  32'(mem_req_valid_o), 32'd0);
                chk("rst_mid_req_addr",   mem_req_addr_o, 32'd0);
                chk("rst_mid_pulses",     32'({refill_valid_o, fault_valid_o}), 32'd0);
                chk("rst_mid_refill_ppn", 32'(refill_ppn_o), 32'd0);
                chk("rst_mid_refill_vpn", 32'(refill_vpn_o), 32'd0);
                chk("rst_mid_fields",     32'({refill_asid_o, refill_flags_o, refill_global_o}), 32'd0);
                chk("rst_mid_fault_vpn",  32'(fault_vpn_o), 32'd0);
                return;
            end
            #1;
            if (busy_o === miss_ready_o) busy_bad++;
            if (mem_req_valid_o && first_req_k < 0) first_req_k = k;
            if (refill_valid_o) begin
                n_refill++; refill_k = k;
                cap_ppn = refill_ppn_o; cap_vpn = refill_vpn_o; cap_asid = refill_asid_o;
                cap_flags = refill_flags_o; cap_glb = refill_global_o;
            end
            if (fault_valid_o) begin
                n_fault++; fault_k = k; cap_fvpn = fault_vpn_o;
            end
            if (miss_ready_o) begin
                done_k = k;
                break;
            end
        end
        abort_i = 1'b0;
        if (done_k < 0) chk("walk_timeout", 32'd0, 32'd1);
    endtask

    task automatic fault_case(input string tag, input logic [19:0] vpn,
                              input logic [19:0] satp, input int exp_k);
        run_walk(vpn, 8'h11, satp, -1, -1);
        chk({tag, "_fault_cnt"},  32'(n_fault), 32'd1);
        chk({tag, "_fault_k"},    32'(fault_k), 32'(exp_k));
        chk({tag, "_fault_vpn"},  32'(cap_fvpn), 32'(vpn));
        chk({tag, "_no_refill"},  32'(n_refill), 32'd0);
    endtask

    initial begin : main
        // PTE images: L1 entries at {satp, vpn[19:10], 00}, L0 at {ppn, vpn[9:0], 00}
        mem[32'h0001_0120] = 32'h0002_0001;  // vpn 0x12345, root 0x10: pointer
        mem[32'h0002_0D14] = 32'hABCD_E03F;  // L0 leaf, all perms + G
        mem[32'h0001_1120] = 32'h4000_0007;  // root 0x11: aligned superpage R,W,V
        mem[32'h0001_2004] = 32'h0000_0000;  // root 0x12: invalid
        mem[32'h0001_3004] = 32'h4000_1007;  // root 0x13: misaligned superpage
        mem[32'h0001_4004] = 32'h0003_0001;  // root 0x14: pointer
        mem[32'h0003_000C] = 32'h0003_0001;  //   ... to another pointer at L0
        mem[32'h0001_7004] = 32'h0005_0005;  // root 0x17: W without R
        mem[32'h0001_50A8] = 32'h0040_0003;  // root 0x15, vpn 0x0ABCD: superpage R,V
        mem[32'h0001_6120] = 32'h0006_0001;  // root 0x16: pointer (aborted walk)

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_miss_ready", 32'(miss_ready_o), 32'd1);
        chk("rst_busy",       32'(busy_o), 32'd0);
        chk("rst_req_valid",  32'(mem_req_valid_o), 32'd0);
        chk("rst_req_addr",   mem_req_addr_o, 32'd0);
        chk("rst_pulses",     32'({refill_valid_o, fault_valid_o}), 32'd0);
        chk("rst_refill_ppn", 32'(refill_ppn_o), 32'd0);
        chk("rst_fault_vpn",  32'(fault_vpn_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // two-level walk to an L0 leaf
        run_walk(20'h12345, 8'h5A, 20'h00010, -1, -1);
        chk("l0_req_cnt",   32'(req_log.size()), 32'd2);
        chk("l0_addr_l1",   logged(0), 32'h0001_0120);
        chk("l0_addr_l0",   logged(1), 32'h0002_0D14);
        chk("l0_first_req", 32'(first_req_k), 32'd1);
        chk("l0_refill_k",  32'(refill_k), 32'd5);
        chk("l0_done_k",    32'(done_k), 32'd6);
        chk("l0_refill_n",  32'(n_refill), 32'd1);
        chk("l0_fault_n",   32'(n_fault), 32'd0);
        chk("l0_ppn",       32'(cap_ppn), 32'h000A_BCDE);
        chk("l0_vpn",       32'(cap_vpn), 32'h0001_2345);
        chk("l0_asid",      32'(cap_asid), 32'h5A);
        chk("l0_flags",     32'(cap_flags), 32'hF);
        chk("l0_global",    32'(cap_glb), 32'd1);

        // aligned superpage: single read, split to the missing 4 KB page
        run_walk(20'h12345, 8'h3C, 20'h00011, -1, -1);
        chk("sp_req_cnt",  32'(req_log.size()), 32'd1);
        chk("sp_addr",     logged(0), 32'h0001_1120);
        chk("sp_refill_k", 32'(refill_k), 32'd3);
        chk("sp_done_k",   32'(done_k), 32'd4);
        chk("sp_ppn",      32'(cap_ppn), 32'h0004_0345);
        chk("sp_flags",    32'(cap_flags), 32'h3);
        chk("sp_global",   32'(cap_glb), 32'd0);
        chk("sp_asid",     32'(cap_asid), 32'h3C);

        // faults
        fault_case("f_invalid",  20'h00401, 20'h00012, 3);
        fault_case("f_misalign", 20'h00402, 20'h00013, 3);
        fault_case("f_l0_ptr",   20'h00403, 20'h00014, 5);
        chk("f_l0_ptr_addr", logged(1), 32'h0003_000C);
        fault_case("f_w_no_r",   20'h00404, 20'h00017, 3);

        // backpressure: ready held off 3 cycles, response 4 cycles late
        rdy_dly = 3; rsp_dly = 4; addr_unstable = 0;
        run_walk(20'h0ABCD, 8'h77, 20'h00015, -1, -1);
        rdy_dly = 0; rsp_dly = 0;
        chk("bp_addr",        logged(0), 32'h0001_50A8);
        chk("bp_addr_stable", 32'(addr_unstable), 32'd0);
        chk("bp_refill_k",    32'(refill_k), 32'd10);
        chk("bp_refill_n",    32'(n_refill), 32'd1);
        chk("bp_done_k",      32'(done_k), 32'd11);
        chk("bp_ppn",         32'(cap_ppn), 32'h0000_07CD);
        chk("bp_flags",       32'(cap_flags), 32'h1);

        // abort while waiting for the L1 response
        rsp_dly = 2;
        run_walk(20'h12345, 8'h01, 20'h00016, 2, -1);
        rsp_dly = 0;
        chk("abw_req_cnt",  32'(req_log.size()), 32'd1);
        chk("abw_refill_n", 32'(n_refill), 32'd0);
        chk("abw_fault_n",  32'(n_fault), 32'd0);
        chk("abw_done_k",   32'(done_k), 32'd5);
        run_walk(20'h12345, 8'h02, 20'h00011, -1, -1);
        chk("abw_next_refill_k", 32'(refill_k), 32'd3);
        chk("abw_next_ppn",      32'(cap_ppn), 32'h0004_0345);

        // abort in the refill cycle
        run_walk(20'h12345, 8'h03, 20'h00011, 3, -1);
        chk("abr_refill_n", 32'(n_refill), 32'd0);
        chk("abr_fault_n",  32'(n_fault), 32'd0);
        chk("abr_done_k",   32'(done_k), 32'd4);

        // reset in L0_WAIT, then a clean walk
        run_walk(20'h12345, 8'h44, 20'h00010, -1, 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_walk(20'h12345, 8'h45, 20'h00010, -1, -1);
        chk("post_rst_refill_k", 32'(refill_k), 32'd5);
        chk("post_rst_ppn",      32'(cap_ppn), 32'h000A_BCDE);
        chk("post_rst_asid",     32'(cap_asid), 32'h45);

        chk("busy_vs_ready", 32'(busy_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
